knn_vote: RTL

- Result-side consumer of the K-nearest sorter; reads the sorter's ranked neighbour indices by driving its select input.
- Looks up each neighbour's class label in an external label memory, builds a per-class vote histogram, and returns the majority class.
- Sits between the sorter and the CPU register interface; started once the sorter has seen its last training point.

---
 rtl/knn_pkg.sv | 28 ++
 rtl/knn_vote_if.sv | 36 +++
 rtl/knn_hist.sv | 41 ++++
 rtl/knn_vote.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// knn_pkg: constants shared between the K-nearest sorter and the vote block,
// the vote controller state encoding, and histogram counter sizing.
package knn_pkg;

    // Defaults shared with the sorter: neighbour slots, index and label widths.
    localparam int K_DEF     = 4;
    localparam int IDX_W_DEF = 8;
    localparam int LBL_W_DEF = 4;

    // A class count can reach at most K + (K-1) + ... + 1 in the weighted
    // build, so counters are sized for K*(K+1)/2; the unweighted build
    // (at most K) always fits in the same width.
    function automatic int cnt_width(input int k);
        return $clog2(k * (k + 1) / 2 + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(K_DEF);

    // Vote controller states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_SCAN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/knn_vote_if.sv
// knn_vote_if: bundles the start/result handshake, the sorter rank select
// and the label memory read port of the vote block.
// slave = the vote block, master = the sorter/label memory/CPU side.
interface knn_vote_if
    import knn_pkg::*;
#(
    parameter int K     = K_DEF,
    parameter int IDX_W = IDX_W_DEF,
    parameter int LBL_W = LBL_W_DEF,
    parameter int SEL_W = (K > 1) ? $clog2(K) : 1
) ();

    logic             start;
    logic [IDX_W-1:0] npts;
    logic [SEL_W-1:0] sel;
    logic [IDX_W-1:0] idx;
    logic             lbl_rd_en;
    logic [IDX_W-1:0] lbl_addr;
    logic [LBL_W-1:0] lbl_data;
    logic [LBL_W-1:0] label_out;
    logic             empty;
    logic             valid;
    logic             ack;
    logic             busy;

    modport slave (
        input  start, npts, idx, lbl_data, ack,
        output sel, lbl_rd_en, lbl_addr, label_out, empty, valid, busy
    );

    modport master (
        output start, npts, idx, lbl_data, ack,
        input  sel, lbl_rd_en, lbl_addr, label_out, empty, valid, busy
    );

endinterface

// File: rtl/knn_hist.sv
// knn_hist: one counter per class. Counters are cleared together at the
// start of a classification, bumped by a weight at the label address, and
// read back combinationally one class at a time during the scan.
module knn_hist
    import knn_pkg::*;
#(
    parameter int AW    = LBL_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             inc_en_i,
    input  logic [AW-1:0]    inc_addr_i,
    input  logic [CNT_W-1:0] inc_wt_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [CNT_W-1:0] rd_cnt_o
);

    localparam int NCLASS = 2 ** AW;

    logic [CNT_W-1:0] cnt_q [NCLASS];

    // Clear wins over increment; the controller never asks for both at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCLASS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (clear_i) begin
            for (int i = 0; i < NCLASS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (inc_en_i) begin
            cnt_q[inc_addr_i] <= cnt_q[inc_addr_i] + inc_wt_i;
        end
    end

    assign rd_cnt_o = cnt_q[rd_addr_i];

endmodule

// File: rtl/knn_vote.sv
// knn_vote: reads the sorter's ranked neighbours, looks up each neighbour's
// class label, accumulates a per-class vote histogram and reports the
// majority class, with ties going to the nearest neighbour's class.
// Optional build macro KNN_VOTE_WEIGHT_EN: rank r votes with weight K-r
// instead of 1. Ports and latency do not change.
module knn_vote
    import knn_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    knn_vote_if.slave  bus
);

    localparam int K      = K_DEF;
    localparam int IDX_W  = IDX_W_DEF;
    localparam int LBL_W  = LBL_W_DEF;
    localparam int NCLASS = 2 ** LBL_W;
    localparam int SEL_W  = (K > 1) ? $clog2(K) : 1;
    localparam int CNT_W  = cnt_width(K);

    state_t           state_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] last_q;
    logic             rd_en_q;
    logic             pend_q;
    logic [SEL_W-1:0] pend_rank_q;
    logic [LBL_W-1:0] seed_q;
    logic [LBL_W-1:0] scan_q;
    logic [LBL_W-1:0] best_lbl_q;
    logic [CNT_W-1:0] best_cnt_q;
    logic [LBL_W-1:0] label_q;
    logic             empty_q;
    logic             valid_q;
    logic             busy_q;

    logic [SEL_W-1:0] last_d;
    logic [CNT_W-1:0] weight_d;
    logic [CNT_W-1:0] scan_cnt;
    logic             take_d;
    logic             hist_clear;

    // Highest rank to read: min(K, npts) - 1. Only meaningful for npts > 0.
    always_comb begin
        last_d = SEL_W'(K - 1);
        if (bus.npts < IDX_W'(K)) begin
            last_d = SEL_W'(bus.npts - IDX_W'(1));
        end
    end

    // Vote weight of the label arriving this cycle, from the rank that issued it.
    always_comb begin
`ifdef KNN_VOTE_WEIGHT_EN
        weight_d = CNT_W'(K) - CNT_W'(pend_rank_q);
`else
        weight_d = CNT_W'(1);
`endif
    end

    // Scan decision. best_cnt_q starts at zero rather than at the seed's
    // count, so the seed class is allowed to take over on an equal count;
    // afterwards only a strictly larger count displaces it. The outcome is
    // the same as starting from the seed and requiring a strictly larger
    // count, without needing the seed's final count before the scan starts.
    always_comb begin
        take_d = (scan_cnt > best_cnt_q) ||
                 ((scan_cnt == best_cnt_q) && (scan_q == seed_q));
    end

    assign hist_clear = (state_q == ST_IDLE) && bus.start;

    knn_hist #(
        .AW    (LBL_W),
        .CNT_W (CNT_W)
    ) u_hist (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (hist_clear),
        .inc_en_i   (pend_q),
        .inc_addr_i (bus.lbl_data),
        .inc_wt_i   (weight_d),
        .rd_addr_i  (scan_q),
        .rd_cnt_o   (scan_cnt)
    );

    // Controller: rank fetch, read-data pipeline tracking, class scan and result hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            last_q      <= '0;
            rd_en_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_rank_q <= '0;
            seed_q      <= '0;
            scan_q      <= '0;
            best_lbl_q  <= '0;
            best_cnt_q  <= '0;
            label_q     <= '0;
            empty_q     <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            pend_q      <= rd_en_q;
            pend_rank_q <= sel_q;
            if (pend_q && (pend_rank_q == '0)) begin
                seed_q <= bus.lbl_data;
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        busy_q  <= 1'b1;
                        empty_q <= (bus.npts == '0);
                        if (bus.npts == '0) begin
                            state_q <= ST_DONE;
                            label_q <= '0;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_FETCH;
                            last_q  <= last_d;
                            sel_q   <= '0;
                            rd_en_q <= 1'b1;
                        end
                    end
                end

                ST_FETCH: begin
                    if (sel_q == last_q) begin
                        state_q <= ST_DRAIN;
                        sel_q   <= '0;
                        rd_en_q <= 1'b0;
                    end else begin
                        sel_q <= sel_q + SEL_W'(1);
                    end
                end

                ST_DRAIN: begin
                    state_q    <= ST_SCAN;
                    scan_q     <= '0;
                    best_lbl_q <= '0;
                    best_cnt_q <= '0;
                end

                ST_SCAN: begin
                    if (take_d) begin
                        best_lbl_q <= scan_q;
                        best_cnt_q <= scan_cnt;
                    end
                    if (scan_q == LBL_W'(NCLASS - 1)) begin
                        state_q <= ST_DONE;
                        valid_q <= 1'b1;
                        label_q <= take_d ? scan_q : best_lbl_q;
                    end else begin
                        scan_q <= scan_q + LBL_W'(1);
                    end
                end

                ST_DONE: begin
                    if (bus.ack) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sel       = sel_q;
    assign bus.lbl_rd_en = rd_en_q;
    assign bus.lbl_addr  = rd_en_q ? bus.idx : '0;
    assign bus.label_out = label_q;
    assign bus.empty     = empty_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = busy_q;

endmodule
